dbus_mem_responder: RTL and testbench

Responder (slave) end of the data bus (dBUS): accepts `dbus_req_t` requests from a data-side initiator (load/store unit, page-table walker), services them against an internal 64-bit-word SRAM with configurable latency, and returns `dbus_resp_t`. It serves as the on-chip scratchpad and as the simulation memory model behind the memory stage, so initiators are verified against the same handshake used in silicon.

---
 rtl/dbus_mem_responder_pkg.sv | 56 +++++
 rtl/dbus_mem_responder_if.sv | 16 +
 rtl/dbus_mem_responder_sram_array.sv | 42 ++++
 rtl/dbus_mem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_dbus_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dbus_mem_responder_pkg
// Shared dBUS types for the data-side memory responder:
//   msize_t        access size encoding (1/2/4/8 bytes)
//   dbus_req_t     initiator -> responder request
//   dbus_resp_t    responder -> initiator response
//   dresp_state_t  responder handshake state
// plus the size/alignment helper used by the address check.
// ---------------------------------------------------------------------------
package dbus_mem_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    DRESP_IDLE = 2'd0,
    DRESP_WAIT = 2'd1,
    DRESP_RESP = 2'd2
  } dresp_state_t;

  // Width of the latency down-counter; LATENCY is limited to 1..15.
  localparam int unsigned LAT_CNT_W = 4;

  // True when the low address bits are not a multiple of the access size.
  // Unknown size encodings are treated as misaligned so they raise err.
  function automatic logic addr_misaligned(input logic [2:0] addr_lo, input msize_t size);
    logic bad;
    case (size)
      MSIZE1:  bad = 1'b0;
      MSIZE2:  bad = addr_lo[0];
      MSIZE4:  bad = |addr_lo[1:0];
      MSIZE8:  bad = |addr_lo[2:0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dbus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// dbus_mem_responder_if
// dBUS request/response bundle.
//   dreq   request driven by the initiator (master)
//   dresp  response driven by the responder (slave)
// ---------------------------------------------------------------------------
interface dbus_mem_responder_if;
  import dbus_mem_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_mem_responder_sram_array.sv
// ---------------------------------------------------------------------------
// dbus_sram_array
// DEPTH x 64-bit single-port array, byte write enables, synchronous read.
//   clk    clock
//   rd_en  capture mem[addr] into rdata at the next edge
//   wr_be  per-byte write enables (lane i = bits [8i+7:8i])
//   addr   word index shared by read and write
//   wdata  write data
//   rdata  registered read data (holds its value while rd_en is low)
// Contents are not reset.
// ---------------------------------------------------------------------------
module dbus_sram_array #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [7:0]    wr_be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem_r [DEPTH];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_be[i]) begin
        mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Synchronous read port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// ---------------------------------------------------------------------------
// dbus_mem_responder
// dBUS responder backed by an internal SRAM with fixed response latency.
//   clk     clock
//   reset   synchronous, active-high reset
//   dbus    slave side of the dBUS (dreq in, dresp out)
//   err     sticky flag: an out-of-range or misaligned request was accepted
//   rd_cnt  completed reads (strobe == 0), wraps
//   wr_cnt  completed writes (strobe != 0), wraps
// Parameters: DEPTH words of 64 bits starting at byte address BASE;
// LATENCY (1..15) cycles from the accept edge to data_ok.
// ---------------------------------------------------------------------------
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  dbus_mem_responder_if.slave        dbus,
  output logic                       err,
  output logic [31:0]                rd_cnt,
  output logic [31:0]                wr_cnt
);

  localparam int unsigned          AW       = $clog2(DEPTH);
  localparam logic [63:0]          SPAN     = 64'(DEPTH) << 3;
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 32'd1);

  dresp_state_t         state_r;
  dresp_state_t         state_nx_s;
  logic                 accept_s;

  logic [LAT_CNT_W-1:0] cnt_r;
  logic [AW-1:0]        word_r;
  logic [7:0]           strobe_r;
  logic [63:0]          wdata_r;
  logic                 ok_r;

  logic                 err_r;
  logic [31:0]          rd_cnt_r;
  logic [31:0]          wr_cnt_r;

  logic [63:0]          off_s;
  logic                 req_ok_s;
  logic [AW-1:0]        req_word_s;

  logic                 sram_rd_s;
  logic [7:0]           sram_be_s;
  logic [AW-1:0]        sram_addr_s;
  logic [63:0]          sram_rdata_s;

  dbus_resp_t           resp_s;

  // Decode of the live request: offset into the array, range and alignment.
  always_comb begin
    off_s      = dbus.dreq.addr - BASE;
    req_ok_s   = (dbus.dreq.addr >= BASE) && (off_s < SPAN) &&
                 !addr_misaligned(dbus.dreq.addr[2:0], dbus.dreq.size);
    req_word_s = off_s[AW+2:3];
  end

  // Next-state logic of the IDLE -> WAIT -> RESP handshake.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      DRESP_IDLE: begin
        if (dbus.dreq.valid) begin
          accept_s   = 1'b1;
          state_nx_s = (LATENCY > 32'd1) ? DRESP_WAIT : DRESP_RESP;
        end else begin
          state_nx_s = DRESP_IDLE;
        end
      end
      DRESP_WAIT: begin
        // cnt_r == 1 here means the decrement this cycle reaches zero.
        if (cnt_r == LAT_CNT_W'(1)) begin
          state_nx_s = DRESP_RESP;
        end else begin
          state_nx_s = DRESP_WAIT;
        end
      end
      DRESP_RESP: state_nx_s = DRESP_IDLE;
      default:    state_nx_s = DRESP_IDLE;
    endcase
  end

  // Array control: the read is issued on the edge entering RESP so rdata is
  // valid during RESP; with LATENCY=1 that edge is the accept edge, so the
  // live request address is used. Writes commit on the RESP edge.
  always_comb begin
    sram_addr_s = word_r;
    sram_rd_s   = 1'b0;
    sram_be_s   = 8'h00;
    case (state_r)
      DRESP_IDLE: begin
        sram_addr_s = req_word_s;
        if (accept_s && (LATENCY == 32'd1) && req_ok_s && (dbus.dreq.strobe == 8'h00)) begin
          sram_rd_s = 1'b1;
        end else begin
          sram_rd_s = 1'b0;
        end
      end
      DRESP_WAIT: begin
        if ((state_nx_s == DRESP_RESP) && ok_r && (strobe_r == 8'h00)) begin
          sram_rd_s = 1'b1;
        end else begin
          sram_rd_s = 1'b0;
        end
      end
      DRESP_RESP: begin
        if (ok_r && !reset) begin
          sram_be_s = strobe_r;
        end else begin
          sram_be_s = 8'h00;
        end
      end
      default: begin
        sram_rd_s = 1'b0;
        sram_be_s = 8'h00;
      end
    endcase
  end

  // Response bundle; data is forced to zero except on a good read's data_ok.
  always_comb begin
    resp_s.addr_ok = (state_r == DRESP_IDLE) && dbus.dreq.valid && !reset;
    resp_s.data_ok = (state_r == DRESP_RESP) && !reset;
    if (resp_s.data_ok && ok_r && (strobe_r == 8'h00)) begin
      resp_s.data = sram_rdata_s;
    end else begin
      resp_s.data = 64'd0;
    end
  end

  assign dbus.dresp = resp_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= DRESP_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request capture on accept and latency down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= '0;
      word_r   <= '0;
      strobe_r <= 8'h00;
      wdata_r  <= 64'd0;
      ok_r     <= 1'b0;
    end else if (accept_s) begin
      cnt_r    <= LAT_LOAD;
      word_r   <= req_word_s;
      strobe_r <= dbus.dreq.strobe;
      wdata_r  <= dbus.dreq.data;
      ok_r     <= req_ok_s;
    end else if (state_r == DRESP_WAIT) begin
      cnt_r    <= cnt_r - LAT_CNT_W'(1);
    end
  end

  // Sticky error flag and completion counters (one per RESP, never both).
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r    <= 1'b0;
      rd_cnt_r <= 32'd0;
      wr_cnt_r <= 32'd0;
    end else begin
      if (accept_s && !req_ok_s) begin
        err_r <= 1'b1;
      end
      if (state_r == DRESP_RESP) begin
        if (strobe_r != 8'h00) begin
          wr_cnt_r <= wr_cnt_r + 32'd1;
        end else begin
          rd_cnt_r <= rd_cnt_r + 32'd1;
        end
      end
    end
  end

  assign err    = err_r;
  assign rd_cnt = rd_cnt_r;
  assign wr_cnt = wr_cnt_r;

  dbus_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .rd_en (sram_rd_s),
    .wr_be (sram_be_s),
    .addr  (sram_addr_s),
    .wdata (wdata_r),
    .rdata (sram_rdata_s)
  );

endmodule

// File: tb/tb_dbus_mem_responder.sv
module tb_dbus_mem_responder;
  import dbus_mem_responder_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  dbus_mem_responder_if bus();

  dbus_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .dbus   (bus.slave),
    .err    (err),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] mem_m [int];
  logic [31:0] rd_m;
  logic [31:0] wr_m;
  logic        err_m;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          dok_cnt = 0;
  logic [63:0] last_data = 64'd0;
  bit          outstanding = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference memory: byte-lane writes on a word map, plain range/alignment rules.
  task automatic model_txn(input logic [63:0] addr, input msize_t size, input logic [7:0] strobe,
                           input logic [63:0] data, output logic [63:0] exp_data);
    longint unsigned nbytes;
    bit              ok;
    int              idx;
    logic [63:0]     w;
    case (size)
      MSIZE1:  nbytes = 1;
      MSIZE2:  nbytes = 2;
      MSIZE4:  nbytes = 4;
      default: nbytes = 8;
    endcase
    ok = (addr >= BASE) && ((addr - BASE) < 64'(DEPTH * 8)) && ((addr % nbytes) == 0);
    if (strobe != 8'h00) wr_m = wr_m + 32'd1;
    else                 rd_m = rd_m + 32'd1;
    exp_data = 64'd0;
    if (!ok) begin
      err_m = 1'b1;
    end else begin
      idx = int'((addr - BASE) / 8);
      if (strobe != 8'h00) begin
        w = mem_m.exists(idx) ? mem_m[idx] : 64'd0;
        for (int i = 0; i < 8; i++) if (strobe[i]) w[i*8 +: 8] = data[i*8 +: 8];
        mem_m[idx] = w;
      end else begin
        exp_data = mem_m.exists(idx) ? mem_m[idx] : 64'd0;
      end
    end
  endtask

  // One full transaction; returns with valid still high just after the RESP edge.
  task automatic do_txn(input logic [63:0] addr, input msize_t size, input logic [7:0] strobe,
                        input logic [63:0] data, output int acc);
    logic [63:0] e;
    int          k;
    acc = -1;
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = addr;
    bus.dreq.size   = size;
    bus.dreq.strobe = strobe;
    bus.dreq.data   = data;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.dresp.addr_ok && k < 50);
    if (!bus.dresp.addr_ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: addr_ok=0 after %0d cycles, expected 1", k);
      return;
    end
    acc = cyc;
    model_txn(addr, size, strobe, data, e);
    exp_q.push_back('{data: e, due: cyc + LAT});
    @(posedge clk); #1;
    // Request fields change while busy; the responder must ignore them.
    bus.dreq.addr   = {$urandom, $urandom};
    bus.dreq.strobe = 8'($urandom);
    bus.dreq.data   = {$urandom, $urandom};
    k = 0;
    while (!bus.dresp.data_ok && k < 50) begin @(negedge clk); k++; end
    if (!bus.dresp.data_ok) begin
      checks++; errors++;
      $display("FAIL resp_timeout: data_ok=0 after %0d cycles, expected 1", k);
      return;
    end
    @(posedge clk); #1;
    check("rd_cnt", 64'(rd_cnt), 64'(rd_m));
    check("wr_cnt", 64'(wr_cnt), 64'(wr_m));
    check("err", 64'(err), 64'(err_m));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every data_ok and polices idle outputs.
  always @(negedge clk) begin
    if (reset) begin
      outstanding = 1'b0;
    end else begin
      if (bus.dresp.addr_ok) begin
        check("addr_ok_while_busy", 64'(outstanding), 64'd0);
        outstanding = 1'b1;
      end
      if (bus.dresp.data_ok) begin
        dok_cnt++;
        outstanding = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_data_ok: data_ok=1 at cycle %0d, expected 0", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_data", bus.dresp.data, mon_e.data);
          check("data_ok_cycle", 64'(cyc), 64'(mon_e.due));
          last_data = bus.dresp.data;
        end
      end
    end
    if (!bus.dresp.data_ok) check("idle_data_zero", bus.dresp.data, 64'd0);
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          a0, a1, a2, d0, k, idx, n;
    logic [63:0] addr, off;
    msize_t      sz;
    logic [7:0]  sb;
    logic [63:0] wd;

    reset = 1'b1;
    bus.dreq = '0;
    bus.dreq.valid = 1'b1;
    rd_m = 32'd0; wr_m = 32'd0; err_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
    check("reset_data_ok", 64'(bus.dresp.data_ok), 64'd0);
    check("reset_data", bus.dresp.data, 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_rd_cnt", 64'(rd_cnt), 64'd0);
    check("reset_wr_cnt", 64'(wr_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.dreq.valid = 1'b0;
    @(posedge clk); #1;

    // Write then read back one doubleword.
    do_txn(64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, a0);
    do_txn(64'h8000_0010, MSIZE8, 8'h00, 64'd0, a0);
    check("sd_readback", last_data, 64'h1122_3344_5566_7788);
    check("first_wr_cnt", 64'(wr_cnt), 64'd1);
    check("first_rd_cnt", 64'(rd_cnt), 64'd1);
    bus.dreq.valid = 1'b0;

    // Known contents for words 0..15 and the last word.
    for (int i = 0; i < 17; i++) begin
      idx = (i == 16) ? int'(DEPTH) - 1 : i;
      if (idx != 2) do_txn(BASE + 64'(idx * 8), MSIZE8, 8'hFF, {$urandom, $urandom}, a0);
    end
    bus.dreq.valid = 1'b0;

    // Single-lane write into an all-ones word.
    do_txn(64'h8000_0008, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, a0);
    do_txn(64'h8000_0008, MSIZE1, 8'h10, 64'h0000_00AB_0000_0000, a0);
    do_txn(64'h8000_0008, MSIZE8, 8'h00, 64'd0, a0);
    check("partial_readback", last_data, 64'hFFFF_FFAB_FFFF_FFFF);
    bus.dreq.valid = 1'b0;
    @(posedge clk); #1;

    // Three reads with valid held high: one accept every LAT+1 cycles.
    d0 = dok_cnt;
    do_txn(BASE, MSIZE8, 8'h00, 64'd0, a0);
    do_txn(BASE + 64'd8, MSIZE8, 8'h00, 64'd0, a1);
    do_txn(BASE + 64'd16, MSIZE8, 8'h00, 64'd0, a2);
    bus.dreq.valid = 1'b0;
    check("b2b_gap1", 64'(a1 - a0), 64'(LAT + 1));
    check("b2b_gap2", 64'(a2 - a1), 64'(LAT + 1));
    check("b2b_dok_count", 64'(dok_cnt - d0), 64'd3);

    // Last in-range word, then just below BASE and just past the end.
    check("err_before_oob", 64'(err), 64'd0);
    do_txn(BASE + 64'(DEPTH * 8 - 8), MSIZE8, 8'h00, 64'd0, a0);
    do_txn(64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, a0);
    check("oob_err_set", 64'(err), 64'd1);
    do_txn(BASE + 64'(DEPTH * 8), MSIZE8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, a0);
    do_txn(BASE, MSIZE8, 8'h00, 64'd0, a0);

    // Misaligned word store leaves the array untouched but still counts.
    do_txn(64'h8000_0002, MSIZE4, 8'h3C, 64'hA5A5_A5A5_A5A5_A5A5, a0);
    do_txn(BASE, MSIZE8, 8'h00, 64'd0, a0);
    check("err_sticky", 64'(err), 64'd1);
    bus.dreq.valid = 1'b0;

    // Randomised traffic over the known words plus illegal addresses.
    for (int t = 0; t < 250; t++) begin
      k   = int'($urandom_range(0, 16));
      idx = (k == 16) ? int'(DEPTH) - 1 : k;
      sz  = msize_t'($urandom_range(0, 3));
      n   = 1 << int'(sz);
      sb  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      wd  = {$urandom, $urandom};
      k   = int'($urandom_range(0, 9));
      off = 64'($urandom_range(0, 7));
      if (k == 0) begin
        addr = ($urandom_range(0, 1) == 0) ? BASE - 64'(8 * $urandom_range(1, 4)) + off
                                           : BASE + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 3)) + off;
      end else if (k == 1 && n > 1) begin
        if ((off % 64'(n)) == 64'd0) off = off | 64'd1;
        addr = BASE + 64'(idx * 8) + off;
      end else begin
        off  = (off / 64'(n)) * 64'(n);
        addr = BASE + 64'(idx * 8) + off;
      end
      do_txn(addr, sz, sb, wd, a0);
      if ($urandom_range(0, 2) == 0) begin
        bus.dreq.valid = 1'b0;
        repeat (int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
    end
    bus.dreq.valid = 1'b0;
    @(posedge clk); #1;

    // Reset while a write is waiting: no response, word unchanged.
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = BASE + 64'd24;
    bus.dreq.size   = MSIZE8;
    bus.dreq.strobe = 8'hFF;
    bus.dreq.data   = ~mem_m[3];
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.dresp.addr_ok && k < 50);
    check("rst_test_accept", 64'(bus.dresp.addr_ok), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.dreq.valid = 1'b0;
    @(negedge clk);
    check("rst_wait_data_ok", 64'(bus.dresp.data_ok), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_m = 32'd0; wr_m = 32'd0; err_m = 1'b0;
    @(negedge clk);
    check("post_rst_addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
    check("post_rst_data_ok", 64'(bus.dresp.data_ok), 64'd0);
    check("post_rst_err", 64'(err), 64'd0);
    check("post_rst_rd_cnt", 64'(rd_cnt), 64'd0);
    check("post_rst_wr_cnt", 64'(wr_cnt), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    do_txn(BASE + 64'd24, MSIZE8, 8'h00, 64'd0, a0);
    do_txn(BASE + 64'd24, MSIZE4, 8'h0F, 64'h0BAD_F00D_0BAD_F00D, a0);
    do_txn(BASE + 64'd24, MSIZE8, 8'h00, 64'd0, a0);
    bus.dreq.valid = 1'b0;

    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
